pb_code_loader: RTL and testbench

- Byte-stream program loader that sits directly upstream of the PicoBlaze program store's load (write) port.
- Receives framed bytes from the host serial/command path and assembles 18-bit instructions.
- Writes each instruction through the store's load interface; LOAD_CLK of the store is tied to CLK.
- Holds the PicoBlaze in reset while a load is in progress and reports completion or error.

---
 rtl/pb_code_loader.sv | 142 ++++++++++++++
 tb/tb_pb_code_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pb_code_loader.sv
// rtl/pb_code_loader.sv - framed byte-stream loader for the PicoBlaze program store.
// Assembles 18-bit words, writes them one cycle after the B0 byte, and holds the core in reset while loading.
module pb_code_loader #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 1000000,
   parameter int         TO_W           = 20
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [7:0]  DATA,
   input  logic        DATA_VALID,
   output logic [9:0]  LOAD_ADDRESS,
   output logic [17:0] LOAD_INSTRUCTION,
   output logic        LOAD_WE,
   output logic        PB_RESET,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERROR
);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR_HI, S_ADDR_LO, S_CNT_HI, S_CNT_LO,
      S_INS_B2, S_INS_B1, S_INS_B0, S_CHECK
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t          r_state;
   state_t          w_next;
   logic [9:0]      r_addr;
   logic [17:0]     r_instr;
   logic            r_we;
   logic            r_pb_reset;
   logic            r_done;
   logic            r_error;
   logic [7:0]      r_chk;
   logic [7:0]      r_cnt_hi;
   logic [15:0]     r_cnt;
   logic [TO_W-1:0] r_to;

   logic [7:0]  w_sum;
   logic [15:0] w_count;
   logic        w_cnt_bad;
   logic        w_to_expire;

   assign w_sum       = r_chk + DATA;
   assign w_count     = {r_cnt_hi, DATA};
   assign w_cnt_bad   = (w_count == 16'd0) || (w_count > 16'd1024);
   // A byte arriving in the expiry cycle takes priority over the timeout.
   assign w_to_expire = (r_state != S_IDLE) && !DATA_VALID && (r_to == TO_LAST);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_to_expire) begin
         w_next = S_IDLE;
      end else if (DATA_VALID) begin
         case (r_state)
            S_IDLE:    if (DATA == SYNC_BYTE) w_next = S_ADDR_HI;
            S_ADDR_HI: w_next = S_ADDR_LO;
            S_ADDR_LO: w_next = S_CNT_HI;
            S_CNT_HI:  w_next = S_CNT_LO;
            S_CNT_LO:  w_next = w_cnt_bad ? S_IDLE : S_INS_B2;
            S_INS_B2:  w_next = S_INS_B1;
            S_INS_B1:  w_next = S_INS_B0;
            S_INS_B0:  w_next = (r_cnt == 16'd1) ? S_CHECK : S_INS_B2;
            S_CHECK:   w_next = S_IDLE;
            default:   w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_addr     <= '0;
         r_instr    <= '0;
         r_we       <= 1'b0;
         r_pb_reset <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_chk      <= '0;
         r_cnt_hi   <= '0;
         r_cnt      <= '0;
         r_to       <= '0;
      end else begin
         r_we   <= 1'b0;
         r_done <= 1'b0;
         // Address advances after the write cycle, wrapping naturally at 10 bits.
         if (r_we)   r_addr     <= r_addr + 10'd1;
         if (r_done) r_pb_reset <= 1'b0;
         if (r_state == S_IDLE || DATA_VALID) r_to <= '0;
         else                                 r_to <= r_to + TO_W'(1);

         if (w_to_expire) begin
            r_error <= 1'b1;
         end else if (DATA_VALID) begin
            if (r_state != S_IDLE) r_chk <= w_sum;
            case (r_state)
               S_IDLE: begin
                  if (DATA == SYNC_BYTE) begin
                     r_pb_reset <= 1'b1;
                     r_error    <= 1'b0;
                     r_chk      <= '0;
                  end
               end
               S_ADDR_HI: r_addr[9:8] <= DATA[1:0];
               S_ADDR_LO: r_addr[7:0] <= DATA;
               S_CNT_HI:  r_cnt_hi    <= DATA;
               S_CNT_LO: begin
                  r_cnt <= w_count;
                  if (w_cnt_bad) r_error <= 1'b1;
               end
               S_INS_B2: r_instr[17:16] <= DATA[1:0];
               S_INS_B1: r_instr[15:8]  <= DATA;
               S_INS_B0: begin
                  r_instr[7:0] <= DATA;
                  r_we         <= 1'b1;
                  r_cnt        <= r_cnt - 16'd1;
               end
               S_CHECK: begin
                  if (w_sum == 8'h00) r_done  <= 1'b1;
                  else                r_error <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign LOAD_ADDRESS     = r_addr;
   assign LOAD_INSTRUCTION = r_instr;
   assign LOAD_WE          = r_we;
   assign PB_RESET         = r_pb_reset;
   assign BUSY             = (r_state != S_IDLE);
   assign DONE             = r_done;
   assign ERROR            = r_error;

endmodule

// File: tb/tb_pb_code_loader.sv
// tb/tb_pb_code_loader.sv - self-checking bench for pb_code_loader.
// Frame table plus hand sequences for write timing, timeout and async reset.
module tb_pb_code_loader;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic [7:0]  DATA;
   logic        DATA_VALID;
   logic [9:0]  LOAD_ADDRESS;
   logic [17:0] LOAD_INSTRUCTION;
   logic        LOAD_WE;
   logic        PB_RESET;
   logic        BUSY;
   logic        DONE;
   logic        ERROR;

   always #5 CLK = ~CLK;

   pb_code_loader #(
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (50),
      .TO_W           (20)
   ) dut (
      .CLK              (CLK),
      .RESET_N          (RESET_N),
      .DATA             (DATA),
      .DATA_VALID       (DATA_VALID),
      .LOAD_ADDRESS     (LOAD_ADDRESS),
      .LOAD_INSTRUCTION (LOAD_INSTRUCTION),
      .LOAD_WE          (LOAD_WE),
      .PB_RESET         (PB_RESET),
      .BUSY             (BUSY),
      .DONE             (DONE),
      .ERROR            (ERROR)
   );

   typedef struct {
      logic [7:0]  b [16];
      int          n;
      int          exp_we;
      logic [9:0]  a0, a1;
      logic [17:0] i0, i1;
      int          exp_done;
      logic        exp_err;
      logic        exp_pbr;
   } vec_t;

   vec_t        tv [7];
   logic [9:0]  wa_q [$];
   logic [17:0] wi_q [$];
   int          done_cnt;
   int          errors = 0;
   int          checks = 0;

   always @(negedge CLK) begin
      if (LOAD_WE) begin
         wa_q.push_back(LOAD_ADDRESS);
         wi_q.push_back(LOAD_INSTRUCTION);
      end
      if (DONE) done_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      DATA       = b;
      DATA_VALID = 1'b1;
      @(negedge CLK);
      DATA_VALID = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // good single word; checksum of 00 10 00 01 03 12 34 is 5A, so CHK = A6
      tv[0].b = '{8'hA5,8'h00,8'h10,8'h00,8'h01,8'h03,8'h12,8'h34,8'hA6,0,0,0,0,0,0,0};
      tv[0].n = 9;  tv[0].exp_we = 1; tv[0].a0 = 10'h010; tv[0].i0 = 18'h31234;
      tv[0].a1 = 0; tv[0].i1 = 0; tv[0].exp_done = 1; tv[0].exp_err = 0; tv[0].exp_pbr = 0;
      // wrap 3FF -> 000, two words
      tv[1].b = '{8'hA5,8'h03,8'hFF,8'h00,8'h02,8'h01,8'hAB,8'hCD,8'h02,8'h55,8'h66,8'hC6,0,0,0,0};
      tv[1].n = 12; tv[1].exp_we = 2; tv[1].a0 = 10'h3FF; tv[1].i0 = 18'h1ABCD;
      tv[1].a1 = 10'h000; tv[1].i1 = 18'h25566; tv[1].exp_done = 1; tv[1].exp_err = 0; tv[1].exp_pbr = 0;
      // garbage in IDLE
      tv[2].b = '{8'h00,8'hFF,8'h5A,0,0,0,0,0,0,0,0,0,0,0,0,0};
      tv[2].n = 3;  tv[2].exp_we = 0; tv[2].a0 = 0; tv[2].i0 = 0; tv[2].a1 = 0; tv[2].i1 = 0;
      tv[2].exp_done = 0; tv[2].exp_err = 0; tv[2].exp_pbr = 0;
      // bad checksum
      tv[3] = tv[0];
      tv[3].b[8] = 8'hA7; tv[3].exp_done = 0; tv[3].exp_err = 1; tv[3].exp_pbr = 1;
      // good frame recovers
      tv[4] = tv[0];
      // N = 0
      tv[5].b = '{8'hA5,8'h00,8'h00,8'h00,8'h00,0,0,0,0,0,0,0,0,0,0,0};
      tv[5].n = 5;  tv[5].exp_we = 0; tv[5].a0 = 0; tv[5].i0 = 0; tv[5].a1 = 0; tv[5].i1 = 0;
      tv[5].exp_done = 0; tv[5].exp_err = 1; tv[5].exp_pbr = 1;
      // N = 1025
      tv[6] = tv[5];
      tv[6].b[3] = 8'h04; tv[6].b[4] = 8'h01;

      RESET_N    = 1'b1;
      DATA       = 8'h00;
      DATA_VALID = 1'b0;
      done_cnt   = 0;
      #3 RESET_N = 1'b0;
      @(negedge CLK);
      check("reset_we",    {31'b0, LOAD_WE}, 0);
      check("reset_addr",  {22'b0, LOAD_ADDRESS}, 0);
      check("reset_instr", {14'b0, LOAD_INSTRUCTION}, 0);
      check("reset_pbr",   {31'b0, PB_RESET}, 0);
      check("reset_busy",  {31'b0, BUSY}, 0);
      check("reset_done",  {31'b0, DONE}, 0);
      check("reset_err",   {31'b0, ERROR}, 0);
      @(negedge CLK);
      RESET_N = 1'b1;
      idle(1);

      for (int k = 0; k < 7; k++) begin
         wa_q.delete();
         wi_q.delete();
         done_cnt = 0;
         for (int i = 0; i < tv[k].n; i++) send(tv[k].b[i]);
         idle(3);
         check($sformatf("v%0d_we_count", k), wa_q.size(), tv[k].exp_we);
         if (tv[k].exp_we > 0 && wa_q.size() > 0) begin
            check($sformatf("v%0d_addr0", k),  {22'b0, wa_q[0]}, {22'b0, tv[k].a0});
            check($sformatf("v%0d_instr0", k), {14'b0, wi_q[0]}, {14'b0, tv[k].i0});
         end
         if (tv[k].exp_we > 1 && wa_q.size() > 1) begin
            check($sformatf("v%0d_addr1", k),  {22'b0, wa_q[1]}, {22'b0, tv[k].a1});
            check($sformatf("v%0d_instr1", k), {14'b0, wi_q[1]}, {14'b0, tv[k].i1});
         end
         check($sformatf("v%0d_done", k), done_cnt, tv[k].exp_done);
         check($sformatf("v%0d_err", k),  {31'b0, ERROR},    {31'b0, tv[k].exp_err});
         check($sformatf("v%0d_pbr", k),  {31'b0, PB_RESET}, {31'b0, tv[k].exp_pbr});
         check($sformatf("v%0d_busy", k), {31'b0, BUSY}, 0);
      end

      // write latency and PB_RESET release timing
      send(8'hA5);
      check("seq_pbr_set",  {31'b0, PB_RESET}, 1);
      check("seq_busy_set", {31'b0, BUSY}, 1);
      check("seq_err_clr",  {31'b0, ERROR}, 0);
      send(8'h00); send(8'h10); send(8'h00); send(8'h01); send(8'h03); send(8'h12);
      check("seq_we_before", {31'b0, LOAD_WE}, 0);
      send(8'h34);
      check("seq_we_pulse",  {31'b0, LOAD_WE}, 1);
      check("seq_we_addr",   {22'b0, LOAD_ADDRESS}, 32'h010);
      check("seq_we_instr",  {14'b0, LOAD_INSTRUCTION}, 32'h31234);
      idle(1);
      check("seq_we_end",    {31'b0, LOAD_WE}, 0);
      check("seq_addr_inc",  {22'b0, LOAD_ADDRESS}, 32'h011);
      send(8'hA6);
      check("seq_done_pulse", {31'b0, DONE}, 1);
      check("seq_pbr_hold",   {31'b0, PB_RESET}, 1);
      idle(1);
      check("seq_done_end",   {31'b0, DONE}, 0);
      check("seq_pbr_rel",    {31'b0, PB_RESET}, 0);
      check("seq_busy_end",   {31'b0, BUSY}, 0);

      // timeout expiry after ADDR_LO
      send(8'hA5); send(8'h00); send(8'h10);
      idle(49);
      check("to_not_yet", {31'b0, BUSY}, 1);
      idle(1);
      check("to_busy", {31'b0, BUSY}, 0);
      check("to_err",  {31'b0, ERROR}, 1);
      check("to_pbr",  {31'b0, PB_RESET}, 1);

      // byte in the expiry cycle wins
      send(8'hA5); send(8'h00); send(8'h10);
      idle(49);
      send(8'h00);
      check("to_win_busy", {31'b0, BUSY}, 1);
      check("to_win_err",  {31'b0, ERROR}, 0);
      idle(50);
      check("to_late_err", {31'b0, ERROR}, 1);

      // async reset mid-instruction
      wa_q.delete();
      wi_q.delete();
      send(8'hA5); send(8'h00); send(8'h10); send(8'h00); send(8'h01); send(8'h03); send(8'h12);
      DATA       = 8'h34;
      DATA_VALID = 1'b1;
      #2 RESET_N = 1'b0;
      #1;
      check("ar_pbr",  {31'b0, PB_RESET}, 0);
      check("ar_busy", {31'b0, BUSY}, 0);
      check("ar_err",  {31'b0, ERROR}, 0);
      check("ar_addr", {22'b0, LOAD_ADDRESS}, 0);
      @(negedge CLK);
      DATA_VALID = 1'b0;
      RESET_N    = 1'b1;
      idle(3);
      check("ar_no_we",    wa_q.size(), 0);
      check("ar_busy_after", {31'b0, BUSY}, 0);
      check("ar_pbr_after",  {31'b0, PB_RESET}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
